tt_um_priority_decoder: RTL



---
 rtl/tt_priority_pkg.sv | 32 +++
 rtl/priority_code_fifo.sv | 62 ++++++
 rtl/tt_um_priority_decoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tt_priority_pkg.sv
// Shared definitions for the priority-code decoder: field widths, the output
// FSM state type, and bit positions of the ui_in control fields and the
// uio_out status fields.
package tt_priority_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // ui_in fields
  localparam int CODE_LSB    = 0;
  localparam int VALID_BIT   = 3;
  localparam int CLR_OVF_BIT = 4;
  localparam int FLUSH_BIT   = 5;

  // uio_out status fields
  localparam int ST_READY_BIT  = 0;
  localparam int ST_BUSY_BIT   = 1;
  localparam int ST_OVF_BIT    = 2;
  localparam int ST_EMPTY_BIT  = 3;
  localparam int ST_CODE_LSB   = 4;
  localparam int ST_ACTIVE_BIT = 7;

  function automatic logic [ONEHOT_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    return ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/priority_code_fifo.sv
// Synchronous FIFO of priority codes.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push, wr_data - write request; ignored while full (even if popping)
//   pop, rd_data  - read request; rd_data shows the head entry
//   flush         - empties the FIFO on the next edge; beats push/pop
//   full, empty   - derived from the registered occupancy count
//   count         - current occupancy
module priority_code_fifo
  import tt_priority_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [CODE_W-1:0]          wr_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [CODE_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_priority_decoder.sv
// Priority-code decoder: buffers incoming 3-bit codes and shows each one as a
// one-hot byte on uo_out for HOLD_CYCLES cycles, back-to-back when queued.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   ena       - low freezes all state
//   ui_in     - [2:0] code, [3] in_valid, [4] clear_ovf, [5] flush
//   uio_in    - unused
//   uo_out    - registered one-hot of the displayed code, 0 when idle
//   uio_out   - [0] in_ready [1] busy [2] overflow [3] empty
//               [6:4] displayed code [7] out_active
//   uio_oe    - all outputs
//
// state | meaning
// IDLE  | nothing displayed, uo_out = 0, waiting for a queued code
// SHOW  | a code is on uo_out; hold_cnt counts remaining cycles minus one
module tt_um_priority_decoder
  import tt_priority_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  logic [CODE_W-1:0]       in_code;
  logic                    in_valid;
  logic                    clr_ovf;
  logic                    flush;

  logic [CODE_W-1:0]       fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_flush;

  state_t                  state, state_nxt;
  logic [7:0]              hold_cnt, hold_cnt_nxt;
  logic [ONEHOT_W-1:0]     onehot_q, onehot_nxt;
  logic [CODE_W-1:0]       disp_code, disp_code_nxt;
  logic                    ovf_q, ovf_nxt;
  logic                    ovf_set;

  logic                    unused_ok;
  assign unused_ok = ^{uio_in, ui_in[7:6], fifo_count};

  assign in_code  = ui_in[CODE_LSB +: CODE_W];
  assign in_valid = ui_in[VALID_BIT];
  assign clr_ovf  = ui_in[CLR_OVF_BIT];
  assign flush    = ui_in[FLUSH_BIT];

  // Flush beats push; the FIFO itself refuses pushes while full.
  assign fifo_push  = ena & in_valid & ~flush;
  assign fifo_flush = ena & flush;

  priority_code_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (in_code),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A dropped code on a flush cycle is not an overflow; set beats clear.
  assign ovf_set = ena & in_valid & fifo_full & ~flush;
  assign ovf_nxt = ovf_set | (ovf_q & ~(ena & clr_ovf));

  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    onehot_nxt    = onehot_q;
    disp_code_nxt = disp_code;
    fifo_pop      = 1'b0;

    if (ena) begin
      if (flush) begin
        state_nxt     = IDLE;
        hold_cnt_nxt  = '0;
        onehot_nxt    = '0;
        disp_code_nxt = '0;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_empty) begin
              fifo_pop      = 1'b1;
              state_nxt     = SHOW;
              hold_cnt_nxt  = HOLD_LOAD;
              onehot_nxt    = code_to_onehot(fifo_head);
              disp_code_nxt = fifo_head;
            end
          end
          SHOW: begin
            if (hold_cnt != '0) begin
              hold_cnt_nxt = hold_cnt - 8'd1;
            end else if (!fifo_empty) begin
              // Next code replaces the current one with no idle gap.
              fifo_pop      = 1'b1;
              hold_cnt_nxt  = HOLD_LOAD;
              onehot_nxt    = code_to_onehot(fifo_head);
              disp_code_nxt = fifo_head;
            end else begin
              state_nxt     = IDLE;
              onehot_nxt    = '0;
              disp_code_nxt = '0;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      onehot_q  <= '0;
      disp_code <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      onehot_q  <= onehot_nxt;
      disp_code <= disp_code_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  always_comb begin
    uio_out                               = '0;
    uio_out[ST_READY_BIT]                 = ~fifo_full;
    uio_out[ST_BUSY_BIT]                  = (state == SHOW) | ~fifo_empty;
    uio_out[ST_OVF_BIT]                   = ovf_q;
    uio_out[ST_EMPTY_BIT]                 = fifo_empty;
    uio_out[ST_CODE_LSB +: CODE_W]        = disp_code;
    uio_out[ST_ACTIVE_BIT]                = (state == SHOW);
  end

  assign uo_out = onehot_q;
  assign uio_oe = 8'hFF;

endmodule
